// File: rtl/schmidl_cox_autocorr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// schmidl_cox_autocorr - sliding delayed autocorrelation P[n] = sum x[k]*conj(x[k-L]).
// Define SC_AUTOCORR_FILL_MASK_EN to drop partial-window sums.   Rev 1.0
// ---------------------------------------------------------------------------
module schmidl_cox_autocorr #(
  parameter int SAMP_W = 16,
  parameter int WINDOW = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       clear,
  input  logic [4*SAMP_W-1:0]                        s_axis_tdata,
  input  logic                                       s_axis_tlast,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  output logic [2*(2*SAMP_W+1+$clog2(WINDOW))-1:0]   m_axis_tdata,
  output logic                                       m_axis_tlast,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready
);
  localparam int MUL_W  = 2*SAMP_W;
  localparam int PROD_W = 2*SAMP_W+1;
  localparam int PTR_W  = $clog2(WINDOW);
  localparam int ACC_W  = PROD_W + PTR_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(WINDOW);

  logic rst_all;
  logic en;
  logic signed [SAMP_W-1:0] cur_re, cur_im, dly_re, dly_im;

  logic                     v1_q, last1_q;
  logic signed [MUL_W-1:0]  rr_q, ii_q, ir_q, ri_q;
  logic                     v2_q, last2_q;
  logic signed [PROD_W-1:0] c_re_q, c_im_q;
  logic                     v3_q, last3_q, restart_q;
  logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W:0]           fill_q;
  logic signed [PROD_W-1:0] win_re_q [WINDOW];
  logic signed [PROD_W-1:0] win_im_q [WINDOW];

  logic signed [PROD_W-1:0] old_re, old_im;
  logic signed [ACC_W-1:0]  base_re, base_im, c_re_x, c_im_x, old_re_x, old_im_x;
  logic signed [ACC_W-1:0]  acc_re_d, acc_im_d;
  logic [PTR_W:0]           fill_d;
  logic                     v3_d;

  assign rst_all = reset | clear;
  assign en      = m_axis_tready | ~v3_q;
  assign s_axis_tready = en;

  assign cur_im = s_axis_tdata[4*SAMP_W-1:3*SAMP_W];
  assign cur_re = s_axis_tdata[3*SAMP_W-1:2*SAMP_W];
  assign dly_im = s_axis_tdata[2*SAMP_W-1:SAMP_W];
  assign dly_re = s_axis_tdata[SAMP_W-1:0];

  // Oldest window entry is only subtracted once the window has been fully populated.
  always_comb begin
    old_re = '0;
    old_im = '0;
    if (fill_q == FULL) begin
      old_re = win_re_q[wr_ptr_q];
      old_im = win_im_q[wr_ptr_q];
    end
    base_re  = restart_q ? '0 : acc_re_q;
    base_im  = restart_q ? '0 : acc_im_q;
    c_re_x   = ACC_W'(c_re_q);
    c_im_x   = ACC_W'(c_im_q);
    old_re_x = ACC_W'(old_re);
    old_im_x = ACC_W'(old_im);
    acc_re_d = base_re + c_re_x - old_re_x;
    acc_im_d = base_im + c_im_x - old_im_x;
    fill_d   = (fill_q == FULL) ? FULL : fill_q + (PTR_W+1)'(1);
`ifdef SC_AUTOCORR_FILL_MASK_EN
    v3_d     = v2_q & ((fill_d == FULL) | last2_q);
`else
    v3_d     = v2_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      rr_q      <= '0;
      ii_q      <= '0;
      ir_q      <= '0;
      ri_q      <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      c_re_q    <= '0;
      c_im_q    <= '0;
      v3_q      <= 1'b0;
      last3_q   <= 1'b0;
      restart_q <= 1'b0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
    end else if (en) begin
      v1_q    <= s_axis_tvalid;
      last1_q <= s_axis_tvalid & s_axis_tlast;
      if (s_axis_tvalid) begin
        rr_q <= MUL_W'(cur_re) * MUL_W'(dly_re);
        ii_q <= MUL_W'(cur_im) * MUL_W'(dly_im);
        ir_q <= MUL_W'(cur_im) * MUL_W'(dly_re);
        ri_q <= MUL_W'(cur_re) * MUL_W'(dly_im);
      end

      v2_q    <= v1_q;
      last2_q <= v1_q & last1_q;
      if (v1_q) begin
        c_re_q <= PROD_W'(rr_q) + PROD_W'(ii_q);
        c_im_q <= PROD_W'(ir_q) - PROD_W'(ri_q);
      end

      v3_q    <= v3_d;
      last3_q <= v2_q & last2_q;
      if (v2_q) begin
        acc_re_q <= acc_re_d;
        acc_im_q <= acc_im_d;
        // A tlast beat closes the window; the following beat starts from zero.
        if (last2_q) begin
          restart_q <= 1'b1;
          wr_ptr_q  <= '0;
          fill_q    <= '0;
        end else begin
          restart_q <= 1'b0;
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
          fill_q    <= fill_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_all && en && v2_q) begin
      win_re_q[wr_ptr_q] <= c_re_q;
      win_im_q[wr_ptr_q] <= c_im_q;
    end
  end

  assign m_axis_tdata  = {acc_im_q, acc_re_q};
  assign m_axis_tvalid = v3_q;
  assign m_axis_tlast  = last3_q;

endmodule
`default_nettype wire

// File: tb/tb_schmidl_cox_autocorr.sv
`default_nettype none
// Bench for schmidl_cox_autocorr: directed and random streams checked against a
// per-packet windowed-sum reference model.
module tb_schmidl_cox_autocorr;
  localparam int SAMP_W = 16;
  localparam int WINDOW = 4;
  localparam int ACC_W  = 2*SAMP_W + 1 + $clog2(WINDOW);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  clear = 1'b0;
  logic [4*SAMP_W-1:0]   s_axis_tdata = '0;
  logic                  s_axis_tlast = 1'b0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic [2*ACC_W-1:0]    m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b1;

  typedef struct { longint re; longint im; bit last; int cyc; } beat_t;
  beat_t  exp_q[$];
  beat_t  got_q[$];
  longint pkt_re[$];
  longint pkt_im[$];

  int n_cmp = 0, n_bad = 0, cyc = 0, stab_err = 0, last_acc_cyc = 0;
  bit rand_ready = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [2*ACC_W-1:0] prev_data = '0;

  schmidl_cox_autocorr #(.SAMP_W(SAMP_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: records every handshake and flags any change while stalled.
  always @(negedge clk) begin
    if (reset || clear) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stab_err++;
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back('{longint'($signed(m_axis_tdata[ACC_W-1:0])),
                          longint'($signed(m_axis_tdata[2*ACC_W-1:ACC_W])), m_axis_tlast, cyc});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Reference: P = sum of the last min(n, WINDOW) products of the current packet.
  task automatic model_beat(input int cr, input int ci, input int dr, input int di, input bit last);
    longint sre = 0, sim = 0;
    int n;
    bit emit = 1'b1;
    pkt_re.push_back(longint'(cr) * dr + longint'(ci) * di);
    pkt_im.push_back(longint'(ci) * dr - longint'(cr) * di);
    n = pkt_re.size();
    for (int k = (n > WINDOW ? n - WINDOW : 0); k < n; k++) begin
      sre += pkt_re[k];
      sim += pkt_im[k];
    end
`ifdef SC_AUTOCORR_FILL_MASK_EN
    emit = (n >= WINDOW) || last;
`endif
    if (emit) exp_q.push_back('{sre, sim, last, 0});
    if (last) begin
      pkt_re.delete();
      pkt_im.delete();
    end
  endtask

  task automatic send_beat(input int cr, input int ci, input int dr, input int di, input bit last);
    bit hs = 1'b0;
    s_axis_tdata  = {SAMP_W'(ci), SAMP_W'(cr), SAMP_W'(di), SAMP_W'(dr)};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = s_axis_tready;
      if (hs) last_acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: s_axis_tready stayed 0, required 1 within 200 cycles");
    end else begin
      model_beat(cr, ci, dr, di, last);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) begin @(posedge clk); #1; end
    idle(8);
  endtask

  task automatic restart();
    rand_ready = 1'b0;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    exp_q.delete(); got_q.delete(); pkt_re.delete(); pkt_im.delete();
    stab_err = 0;
  endtask

  function automatic int rnd_samp();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %0b want 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata got %0h want 0", m_axis_tdata); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready got %0b want 1", s_axis_tready); end
  endtask

  task automatic test_const();
    int first_acc;
    restart();
    send_beat(1000, 0, 1000, 0, 1'b0);
    first_acc = last_acc_cyc;
    for (int i = 1; i < 6; i++) send_beat(1000, 0, 1000, 0, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL const_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im || got_q[i].last !== exp_q[i].last) begin
        n_bad++;
        $display("FAIL const[%0d] got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
    n_cmp++;
`ifdef SC_AUTOCORR_FILL_MASK_EN
    if (got_q.size() == 0 || got_q[0].re !== 64'sd4000000) begin
      n_bad++; $display("FAIL const_first got %0d want 4000000", got_q.size() ? got_q[0].re : -1);
    end
`else
    if (got_q.size() == 0 || got_q[0].re !== 64'sd1000000) begin
      n_bad++; $display("FAIL const_first got %0d want 1000000", got_q.size() ? got_q[0].re : -1);
    end
    n_cmp++;
    if (got_q.size() == 0 || got_q[0].cyc - first_acc !== 3) begin
      n_bad++; $display("FAIL const_latency got %0d want 3", got_q.size() ? got_q[0].cyc - first_acc : -1);
    end
`endif
  endtask

  task automatic test_conj();
    restart();
    for (int i = 0; i < 6; i++) send_beat(0, 1000, 1000, 0, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL conj_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im || got_q[i].last !== exp_q[i].last) begin
        n_bad++;
        $display("FAIL conj[%0d] got (%0d,%0d) want (%0d,%0d)", i, got_q[i].re, got_q[i].im, exp_q[i].re, exp_q[i].im);
      end
    end
    n_cmp++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].im !== 64'sd4000000 || got_q[got_q.size()-1].re !== 64'sd0) begin
      n_bad++; $display("FAIL conj_final got im %0d want 4000000", got_q.size() ? got_q[got_q.size()-1].im : -1);
    end
  endtask

  task automatic test_corner();
    restart();
    for (int i = 0; i < 5; i++) send_beat(-32768, -32768, -32768, -32768, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL corner_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im) begin
        n_bad++;
        $display("FAIL corner[%0d] got (%0d,%0d) want (%0d,%0d)", i, got_q[i].re, got_q[i].im, exp_q[i].re, exp_q[i].im);
      end
    end
    n_cmp++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].re !== 64'sd8589934592) begin
      n_bad++; $display("FAIL corner_final got %0d want 8589934592", got_q.size() ? got_q[got_q.size()-1].re : -1);
    end
  endtask

  task automatic test_packets();
    int j;
    restart();
    for (int i = 0; i < 3; i++) send_beat(1000, 0, 1000, 0, i == 2);
    for (int i = 0; i < 5; i++) send_beat(1000, 0, 1000, 0, i == 4);
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL pkt_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im || got_q[i].last !== exp_q[i].last) begin
        n_bad++;
        $display("FAIL pkt[%0d] got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
    j = 0;
    while (j < got_q.size() && !got_q[j].last) j++;
    n_cmp++;
    if (j + 1 >= got_q.size() || got_q[j].re !== 64'sd3000000) begin
      n_bad++; $display("FAIL pkt_tlast_beat got %0d want 3000000 with tlast", j < got_q.size() ? got_q[j].re : -1);
    end
    n_cmp++;
`ifdef SC_AUTOCORR_FILL_MASK_EN
    if (j + 1 >= got_q.size() || got_q[j+1].re !== 64'sd4000000) begin
      n_bad++; $display("FAIL pkt_restart got %0d want 4000000", j + 1 < got_q.size() ? got_q[j+1].re : -1);
    end
`else
    if (j + 1 >= got_q.size() || got_q[j+1].re !== 64'sd1000000) begin
      n_bad++; $display("FAIL pkt_restart got %0d want 1000000", j + 1 < got_q.size() ? got_q[j+1].re : -1);
    end
`endif
  endtask

  task automatic test_backpressure();
    restart();
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(1000, 0, 1000, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      send_beat(rnd_samp(), rnd_samp(), rnd_samp(), rnd_samp(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im) begin
        n_bad++;
        $display("FAIL bp[%0d] got (%0d,%0d) want (%0d,%0d)", i, got_q[i].re, got_q[i].im, exp_q[i].re, exp_q[i].im);
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable got %0d changes while stalled want 0", stab_err); end
  endtask

  task automatic test_random();
    restart();
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_beat(rnd_samp(), rnd_samp(), rnd_samp(), rnd_samp(), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im || got_q[i].last !== exp_q[i].last) begin
        n_bad++;
        $display("FAIL rnd[%0d] got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin n_bad++; $display("FAIL rnd_stable got %0d changes while stalled want 0", stab_err); end
  endtask

  task automatic test_reset_midstream();
    restart();
    send_beat(1000, 0, 1000, 0, 1'b0);
    send_beat(1000, 0, 1000, 0, 1'b0);
    exp_q.delete(); pkt_re.delete(); pkt_im.delete();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid got %0b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL mid_tdata got %0h want 0", m_axis_tdata); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL mid_tready got %0b want 1", s_axis_tready); end
    idle(6);
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL mid_stale got %0d beats want 0", got_q.size()); end
    for (int i = 0; i < 4; i++) send_beat(1000, 0, 1000, 0, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL mid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im) begin
        n_bad++;
        $display("FAIL mid[%0d] got (%0d,%0d) want (%0d,%0d)", i, got_q[i].re, got_q[i].im, exp_q[i].re, exp_q[i].im);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_const();
    test_conj();
    test_corner();
    test_packets();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
